// File: rtl/flash_sample_reader.sv
// flash_sample_reader
// Fetches one 32-bit word from flash over Avalon-MM for every start_flash
// request, then plays its two packed 16-bit samples (low half first), one per
// sample_tick, and pulses audio_done after the second sample.
// Optional read watchdog: define FLASH_READ_TIMEOUT_EN to enable it.
module flash_sample_reader #(
    parameter int SHIFT          = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_flash,
    input  logic [31:0] byte_address,
    input  logic        sample_tick,
    output logic        flash_mem_read,
    output logic [22:0] flash_mem_address,
    output logic [3:0]  flash_mem_byteenable,
    input  logic        flash_mem_waitrequest,
    input  logic [31:0] flash_mem_readdata,
    input  logic        flash_mem_readdatavalid,
    output logic [15:0] audio_out,
    output logic        audio_valid,
    output logic        audio_done,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        PLAY_LO,
        PLAY_HI
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] word;
    logic [15:0] sample_lo;
    logic [15:0] sample_hi;
    logic        timeout_hit;
    logic        unused_addr_bits;

    // Only the word-address bits of the byte address reach the flash
    assign unused_addr_bits = ^{byte_address[31:25], byte_address[1:0]};

    assign flash_mem_byteenable = 4'b1111;

    // Attenuated samples; arithmetic shift keeps the sign
    assign sample_lo = $signed(word[15:0]) >>> SHIFT;
    assign sample_hi = $signed(word[31:16]) >>> SHIFT;

`ifdef FLASH_READ_TIMEOUT_EN
    logic [31:0] wait_count;
    logic        timeout_flag;

    // Watchdog fires once the read has spent TIMEOUT_CYCLES cycles in flight;
    // data arriving on that same edge still wins
    assign timeout_hit = ((state == REQ) || (state == WAIT_DATA))
                         && (wait_count == 32'(TIMEOUT_CYCLES - 1))
                         && !((state == WAIT_DATA) && flash_mem_readdatavalid);

    assign timeout_err = timeout_flag;

    // Count cycles spent waiting on the flash, restarting with each new request
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_count <= '0;
        end else if ((state == IDLE) && start_flash) begin
            wait_count <= '0;
        end else if ((state == REQ) || (state == WAIT_DATA)) begin
            wait_count <= wait_count + 32'd1;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_flag <= 1'b0;
        end else if (timeout_hit) begin
            timeout_flag <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    // Without the watchdog the read waits indefinitely and the flag never sets
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the state-decoded bus and status outputs
    always_comb begin
        state_next     = state;
        flash_mem_read = (state == REQ);
        busy           = (state != IDLE);
        case (state)
            IDLE:      if (start_flash)             state_next = REQ;
            REQ:       if (!flash_mem_waitrequest)  state_next = WAIT_DATA;
            WAIT_DATA: if (flash_mem_readdatavalid) state_next = PLAY_LO;
            PLAY_LO:   if (sample_tick)             state_next = PLAY_HI;
            PLAY_HI:   if (sample_tick)             state_next = IDLE;
            default:                                state_next = IDLE;
        endcase
        if (timeout_hit) begin
            state_next = PLAY_LO;
        end
    end

    // Address capture, word capture and sample playback strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            flash_mem_address <= '0;
            word              <= '0;
            audio_out         <= '0;
            audio_valid       <= 1'b0;
            audio_done        <= 1'b0;
        end else begin
            audio_valid <= 1'b0;
            audio_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_flash) begin
                        flash_mem_address <= byte_address[24:2];
                    end
                end
                WAIT_DATA: begin
                    if (flash_mem_readdatavalid) begin
                        word <= flash_mem_readdata;
                    end
                end
                PLAY_LO: begin
                    if (sample_tick) begin
                        audio_out   <= sample_lo;
                        audio_valid <= 1'b1;
                    end
                end
                PLAY_HI: begin
                    if (sample_tick) begin
                        audio_out   <= sample_hi;
                        audio_valid <= 1'b1;
                        audio_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (timeout_hit) begin
                word <= '0;
            end
        end
    end

endmodule

// File: doc/flash_sample_reader.md
# flash_sample_reader

Downstream consumer of the address FSM in the speech synthesizer. On each `start_flash` it captures the byte address and performs one 32-bit Avalon-MM read from flash. It then plays the two packed 16-bit samples, lower half first, one per `sample_tick`, and pulses `audio_done` so the address FSM can advance to the next word.

## Interface
- `SHIFT`, default 0: arithmetic right-shift applied to each sample (volume attenuation), legal range 0–15.
- `TIMEOUT_CYCLES`, default 1024: read watchdog limit; only used with `FLASH_READ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_flash`  in  1  fetch request; sampled only in IDLE.
- `byte_address`  in  32  flash byte address, 4-byte aligned (driven by the address FSM's `flash_mem_address`).
- `sample_tick`  in  1  one-cycle sample-rate strobe, already synchronous to `clk`.
- `flash_mem_read`  out  1  Avalon read request.
- `flash_mem_address`  out  23  flash word address.
- `flash_mem_byteenable`  out  4  constant 4'b1111.
- `flash_mem_waitrequest`  in  1  Avalon wait request.
- `flash_mem_readdata`  in  32  read data.
- `flash_mem_readdatavalid`  in  1  read data valid.
- `audio_out`  out  16  signed sample to the audio codec path.
- `audio_valid`  out  1  one-cycle strobe; `audio_out` is new.
- `audio_done`  out  1  one-cycle pulse; the second sample of the word has been issued.
- `busy`  out  1  high whenever the state is not IDLE.
- `timeout_err`  out  1  sticky watchdog flag; tied to 0 without the macro.

## Operation
- States: IDLE, REQ, WAIT_DATA, PLAY_LO, PLAY_HI.
- IDLE: if `start_flash` is high, set `flash_mem_address <= byte_address[24:2]` and go to REQ. Bits [1:0] are ignored.
- REQ: `flash_mem_read` is 1. On an edge where `flash_mem_waitrequest` is 0, go to WAIT_DATA; `flash_mem_read` is 0 from that edge.
- WAIT_DATA: on an edge where `flash_mem_readdatavalid` is 1, capture `flash_mem_readdata` into a 32-bit word register and go to PLAY_LO.
- PLAY_LO: on an edge where `sample_tick` is 1:
  - `audio_out <= $signed(word[15:0]) >>> SHIFT`
  - `audio_valid <= 1`
  - go to PLAY_HI.
- PLAY_HI: on an edge where `sample_tick` is 1:
  - `audio_out <= $signed(word[31:16]) >>> SHIFT`
  - `audio_valid <= 1`, `audio_done <= 1`
  - go to IDLE.
- `audio_valid` and `audio_done` are 0 in every other cycle. `audio_out` holds its value between strobes.
- `busy` is decoded combinationally from the state register.

## Timing
- Reset values: state IDLE; `flash_mem_read` 0; `flash_mem_address` 0; `audio_out` 0; `audio_valid` 0; `audio_done` 0; `busy` 0; `timeout_err` 0. `flash_mem_byteenable` is always 4'b1111.
- Reset is honoured in every state, mid-read included. Outputs take their reset values at the reset edge, and any in-flight read is abandoned.
- `start_flash` sampled at edge N means `flash_mem_read` is high in the cycle after edge N.
- Minimum latency from start to first `audio_valid`: 3 edges plus the wait for a tick. A tick is only acted on while the state is PLAY_LO or PLAY_HI; ticks seen in any other state are dropped.
- A tick and `readdatavalid` on the same edge in WAIT_DATA: the tick is dropped, and PLAY_LO waits for the next tick.
- `readdatavalid` outside WAIT_DATA is ignored.
- `start_flash` outside IDLE is ignored. A start held high in the cycle after `audio_done` begins a new fetch.

## Configuration
- `FLASH_READ_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ and counts every cycle in REQ or WAIT_DATA.
  - When it reaches `TIMEOUT_CYCLES`, `flash_mem_read` drops, the word register is forced to 0, the state goes to PLAY_LO (two silent samples, then `audio_done`), and `timeout_err` is set.
  - `timeout_err` clears only on `reset`.
- `FLASH_READ_TIMEOUT_EN` not defined: no counter exists, WAIT_DATA waits indefinitely, and `timeout_err` is constant 0.

## Test plan
- Basic read: `byte_address` = 0x000104, `waitrequest` low, data 0x8000_7FFF one cycle later, `SHIFT` = 0. Expect `flash_mem_address` = 0x41 and exactly one `flash_mem_read` cycle. The next two ticks give `audio_out` 0x7FFF, then 0x8000 with `audio_done`.
- Wait-request stall: hold `waitrequest` high for 5 cycles. Expect `flash_mem_read` high for 6 cycles and address stable throughout; playback then proceeds normally.
- Shift and back-pressure: with `SHIFT` = 2, data 0xFFF8_0010, and `start_flash` re-pulsed during PLAY_LO, expect outputs 0x0004, then 0xFFFE. The re-pulse is ignored, and `busy` drops the cycle after `audio_done`.
- Simultaneous events and reset: a tick coincides with `readdatavalid` and is not consumed. Asserting `reset` while in WAIT_DATA returns all outputs to their reset values the next cycle, and a late `readdatavalid` afterwards is ignored.
- Timeout (macro defined, `TIMEOUT_CYCLES` = 16, no `readdatavalid`): after 16 cycles `flash_mem_read` is 0 and `timeout_err` is 1. The two following ticks give `audio_out` 0x0000 each, then `audio_done`.
